// File: rtl/vga_pkg.sv
// Shared VGA timing constants and 3-bit colour helpers for the 640x480 image path.
package vga_pkg;

   localparam logic [9:0] H_DAT_BEGIN = 10'd143;
   localparam logic [9:0] H_DAT_END   = 10'd783;
   localparam logic [9:0] V_DAT_BEGIN = 10'd34;
   localparam logic [9:0] V_DAT_END   = 10'd514;
   localparam logic [9:0] H_PIXEL_END = 10'd799;
   localparam logic [9:0] V_LINE_END  = 10'd524;
   localparam logic [9:0] H_VISIBLE   = 10'd640;
   localparam logic [9:0] V_VISIBLE   = 10'd480;

   // Colours are packed {blue,green,red}.
   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] RED   = 3'b001;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] BLUE  = 3'b100;
   localparam logic [2:0] WHITE = 3'b111;

   // Box colour cycles 1..7 and never lands on black.
   function automatic logic [2:0] next_color(input logic [2:0] c);
      return (c == 3'd7) ? 3'd1 : c + 3'd1;
   endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position/direction register that steps by SPEED,
// clamps at 0 and LIMIT, and flags a collision on the step that hits a wall.
module bounce_axis #(
   parameter logic [9:0] LIMIT = 10'd608,
   parameter logic [9:0] SPEED = 10'd2,
   parameter logic [9:0] INIT  = 10'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   output logic [9:0] pos,
   output logic       hit
);

   logic        dir_neg;
   logic [10:0] fwd;

   // Forward sum is 11 bits wide so a position near the limit cannot wrap.
   assign fwd = {1'b0, pos} + {1'b0, SPEED};

   always_comb begin
      hit = 1'b0;
      if (dir_neg)
         hit = (pos <= SPEED);
      else
         hit = (fwd >= {1'b0, LIMIT});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos     <= INIT;
         dir_neg <= 1'b0;
      end else if (step) begin
         if (hit) begin
            pos     <= dir_neg ? 10'd0 : LIMIT;
            dir_neg <= ~dir_neg;
         end else begin
            pos <= dir_neg ? (pos - SPEED) : fwd[9:0];
         end
      end
   end

endmodule

// File: rtl/box_sprite_gen.sv
// Bouncing-box image source: draws a solid box over a background colour and moves it
// once every UPDATE_DIV frames, changing colour whenever it hits a screen edge.
module box_sprite_gen
   import vga_pkg::*;
#(
   parameter logic [9:0] H_DAT_BEGIN = vga_pkg::H_DAT_BEGIN,
   parameter logic [9:0] V_DAT_BEGIN = vga_pkg::V_DAT_BEGIN,
   parameter logic [9:0] H_PIXEL_END = vga_pkg::H_PIXEL_END,
   parameter logic [9:0] V_LINE_END  = vga_pkg::V_LINE_END,
   parameter logic [9:0] BOX_W       = 10'd32,
   parameter logic [9:0] BOX_H       = 10'd32,
   parameter logic [3:0] SPEED       = 4'd2,
   parameter logic [7:0] UPDATE_DIV  = 8'd1,
   parameter logic [9:0] INIT_X      = 10'd100,
   parameter logic [9:0] INIT_Y      = 10'd60,
   parameter logic [2:0] BG_COLOR    = BLACK
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_en,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       freeze,
   output logic [2:0] rgb,
   output logic       bounce
);

   localparam logic [9:0] MAX_X = H_VISIBLE - BOX_W;
   localparam logic [9:0] MAX_Y = V_VISIBLE - BOX_H;

   logic [9:0]  x, y, box_x, box_y;
   logic [10:0] box_x_end, box_y_end;
   logic        visible, in_box, frame_tick, update, step, hit_x, hit_y;
   logic [2:0]  color;
   logic [7:0]  frame_cnt;

   // Counters below the visible start wrap to large values, so one compare covers both sides.
   assign x         = hcount - H_DAT_BEGIN;
   assign y         = vcount - V_DAT_BEGIN;
   assign visible   = (x < H_VISIBLE) && (y < V_VISIBLE);
   assign box_x_end = {1'b0, box_x} + {1'b0, BOX_W};
   assign box_y_end = {1'b0, box_y} + {1'b0, BOX_H};
   assign in_box    = (x >= box_x) && ({1'b0, x} < box_x_end) &&
                      (y >= box_y) && ({1'b0, y} < box_y_end);

   assign frame_tick = (hcount == H_PIXEL_END) && (vcount == V_LINE_END);
   assign update     = frame_tick && (frame_cnt == UPDATE_DIV - 8'd1);
   assign step       = pix_en && update && !freeze;

   bounce_axis #(.LIMIT(MAX_X), .SPEED({6'd0, SPEED}), .INIT(INIT_X)) u_axis_x (
      .clk  (clk),
      .rst  (rst),
      .step (step),
      .pos  (box_x),
      .hit  (hit_x)
   );

   bounce_axis #(.LIMIT(MAX_Y), .SPEED({6'd0, SPEED}), .INIT(INIT_Y)) u_axis_y (
      .clk  (clk),
      .rst  (rst),
      .step (step),
      .pos  (box_y),
      .hit  (hit_y)
   );

   // A corner hit raises both axis flags but still advances the colour only once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb       <= BLACK;
         bounce    <= 1'b0;
         color     <= GREEN;
         frame_cnt <= 8'd0;
      end else if (pix_en) begin
         if (visible && in_box)
            rgb <= color;
         else if (visible)
            rgb <= BG_COLOR;
         else
            rgb <= BLACK;
         bounce <= update && !freeze && (hit_x || hit_y);
         if (frame_tick)
            frame_cnt <= update ? 8'd0 : frame_cnt + 8'd1;
         if (step && (hit_x || hit_y))
            color <= next_color(color);
      end
   end

endmodule
